// File: rtl/vga_timing_pkg.sv
//==============================================================================
// Module      : vga_timing_pkg
// Description : Line timing constants, counter widths and receiver FSM encoding
//               shared by the VGA sync generator and vga_sync_rx.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package vga_timing_pkg;

   localparam int H_TOTAL     = 1600;
   localparam int H_PULSE     = 192;
   localparam int H_BP        = 96;
   localparam int H_DISP      = 1280;
   localparam int H_FP        = 32;
   localparam int CLK_PER_PIX = 10;
   localparam int TOL         = 2;
   localparam int LOCK_LINES  = 4;

   localparam int CNT_W  = 12;
   localparam int PIX_W  = 7;
   localparam int LINE_W = 10;
   localparam int GOOD_W = 3;
   localparam int SUB_W  = 4;
   localparam int BAD_W  = 16;

   localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(2 * H_TOTAL);
   localparam logic [CNT_W-1:0] DISP_FIRST = CNT_W'(H_PULSE + H_BP);
   localparam logic [CNT_W-1:0] DISP_LAST  = CNT_W'(H_PULSE + H_BP + H_DISP - 1);
   localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(H_DISP / CLK_PER_PIX - 1);
   localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(CLK_PER_PIX - 1);
   localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_LINES);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } rx_state_e;

   function automatic logic in_tol(input logic [CNT_W-1:0] val, input int target);
      return (int'(val) >= target - TOL) && (int'(val) <= target + TOL);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
//==============================================================================
// Module      : sync_edge_det
// Description : Two-flop synchronizer plus edge register; one-cycle fall/rise
//               pulses appear three clocks after the pin edge.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module sync_edge_det #(
   parameter logic IDLE_LEVEL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic async_i,
   output logic fall_o,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Reset to the idle level so releasing reset never fabricates an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= IDLE_LEVEL;
         sync_q <= IDLE_LEVEL;
         prev_q <= IDLE_LEVEL;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign fall_o = prev_q & ~sync_q;
   assign rise_o = ~prev_q & sync_q;

endmodule

`default_nettype wire

// File: rtl/vga_sync_rx.sv
//==============================================================================
// Module      : vga_sync_rx
// Description : Locks to incoming VGA hsync/vsync and regenerates pixel column,
//               line index and display-enable. Optional macro
//               VGA_SYNC_RX_STATS_EN adds the BAD_LINES counter and port.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module vga_sync_rx
   import vga_timing_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              VGA_HSYNC,
   input  logic              VGA_VSYNC,
   output logic [PIX_W-1:0]  HPIXEL,
   output logic [LINE_W-1:0] VLINE,
   output logic              DE,
   output logic              LOCKED
`ifdef VGA_SYNC_RX_STATS_EN
   ,
   output logic [BAD_W-1:0]  BAD_LINES
`endif
);

   logic w_hfall, w_hrise, w_vfall, w_vrise_unused;
   logic [CNT_W-1:0] w_period;
   logic w_line_good;

   rx_state_e state_q, state_d;
   logic [GOOD_W-1:0] good_q, good_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  width_q, width_d;
   logic [PIX_W-1:0]  pix_q, pix_d;
   logic [SUB_W-1:0]  sub_q, sub_d;
   logic [LINE_W-1:0] vline_q, vline_d;
   logic de_q, de_d;
   logic locked_q;

   sync_edge_det #(.IDLE_LEVEL(1'b1)) u_hsync_det (
      .clk     (clk),
      .reset   (reset),
      .async_i (VGA_HSYNC),
      .fall_o  (w_hfall),
      .rise_o  (w_hrise)
   );

   sync_edge_det #(.IDLE_LEVEL(1'b1)) u_vsync_det (
      .clk     (clk),
      .reset   (reset),
      .async_i (VGA_VSYNC),
      .fall_o  (w_vfall),
      .rise_o  (w_vrise_unused)
   );

   // Width is captured as cnt+1 so pulse width and period count the same way.
   assign w_period    = cnt_q + CNT_W'(1);
   assign w_line_good = in_tol(w_period, H_TOTAL) && in_tol(width_q, H_PULSE);

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      cnt_d   = cnt_q;
      width_d = width_q;
      vline_d = vline_q;
      pix_d   = '0;
      sub_d   = '0;
      de_d    = 1'b0;

      if (w_hfall)
         cnt_d = '0;
      else if (cnt_q != CNT_SAT)
         cnt_d = cnt_q + CNT_W'(1);

      if (w_hrise)
         width_d = w_period;

      case (state_q)
         ST_SEARCH: begin
            if (w_hfall) begin
               state_d = ST_VERIFY;
               good_d  = '0;
            end
         end
         ST_VERIFY: begin
            if (w_hfall) begin
               if (w_line_good) begin
                  good_d = good_q + GOOD_W'(1);
                  if (good_q + GOOD_W'(1) == GOOD_LOCK)
                     state_d = ST_LOCKED;
               end else begin
                  good_d = '0;
               end
            end
         end
         ST_LOCKED: begin
            if (w_hfall && !w_line_good) begin
               state_d = ST_VERIFY;
               good_d  = '0;
            end
         end
         default: begin
            state_d = ST_SEARCH;
            good_d  = '0;
         end
      endcase

      if (!w_hfall && cnt_q == CNT_SAT) begin
         state_d = ST_SEARCH;
         good_d  = '0;
      end

      if (w_vfall)
         vline_d = '0;
      else if (w_hfall && state_q == ST_LOCKED)
         vline_d = vline_q + LINE_W'(1);

      // Gate on the next state so DE falls in the same cycle as LOCKED.
      if (state_d == ST_LOCKED && cnt_q >= DISP_FIRST && cnt_q <= DISP_LAST) begin
         de_d = 1'b1;
         if (cnt_q == DISP_FIRST) begin
            pix_d = '0;
            sub_d = '0;
         end else if (sub_q == SUB_LAST) begin
            sub_d = '0;
            pix_d = (pix_q == PIX_LAST) ? pix_q : pix_q + PIX_W'(1);
         end else begin
            sub_d = sub_q + SUB_W'(1);
            pix_d = pix_q;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_SEARCH;
         good_q   <= '0;
         cnt_q    <= '0;
         width_q  <= '0;
         pix_q    <= '0;
         sub_q    <= '0;
         vline_q  <= '0;
         de_q     <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         good_q   <= good_d;
         cnt_q    <= cnt_d;
         width_q  <= width_d;
         pix_q    <= pix_d;
         sub_q    <= sub_d;
         vline_q  <= vline_d;
         de_q     <= de_d;
         locked_q <= (state_d == ST_LOCKED);
      end
   end

   assign HPIXEL = pix_q;
   assign VLINE  = vline_q;
   assign DE     = de_q;
   assign LOCKED = locked_q;

`ifdef VGA_SYNC_RX_STATS_EN
   logic [BAD_W-1:0] bad_q, bad_d;

   always_comb begin
      bad_d = bad_q;
      if (w_hfall && !w_line_good && state_q != ST_SEARCH && bad_q != '1)
         bad_d = bad_q + BAD_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         bad_q <= '0;
      else
         bad_q <= bad_d;
   end

   assign BAD_LINES = bad_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_rx.sv
//==============================================================================
// Module      : tb_vga_sync_rx
// Description : Directed line-table bench for vga_sync_rx, plus hand-written
//               vsync, mid-display reset and loss-of-signal sequences.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_sync_rx;

   typedef struct {
      int   per;
      int   wid;
      bit   vs;
      logic lk;
      int   vl;
      int   bad;
   } vec_t;

   logic clk = 1'b0;
   logic reset, hs, vs;
   logic [6:0] hpix;
   logic [9:0] vline;
   logic de, locked;
`ifdef VGA_SYNC_RX_STATS_EN
   logic [15:0] bad_lines;
`endif

   int   n_cmp = 0;
   int   n_bad = 0;
   logic last_lk;

   always #5 clk = ~clk;

   vga_sync_rx dut (
      .clk       (clk),
      .reset     (reset),
      .VGA_HSYNC (hs),
      .VGA_VSYNC (vs),
      .HPIXEL    (hpix),
      .VLINE     (vline),
      .DE        (de),
      .LOCKED    (locked)
`ifdef VGA_SYNC_RX_STATS_EN
      ,
      .BAD_LINES (bad_lines)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_bad(input string nm, input int exp);
`ifdef VGA_SYNC_RX_STATS_EN
      chk(nm, 32'(bad_lines), exp);
`endif
   endtask

   // One hsync line starting with its falling edge; pin edge at cycle P, pulse
   // acts at P+3, so DE is expected for k in [292,1571] and HPIXEL=(k-292)/10.
   task automatic do_line(input string nm, input int per, input int wid, input bit v,
                          input logic exp_lk, input int exp_vl, input int exp_bad);
      int   de_cnt = 0;
      int   errs   = 0;
      logic exp_de;
      int   exp_px;
      @(negedge clk);
      hs = 1'b0;
      if (v) vs = 1'b0;
      for (int k = 1; k < per; k++) begin
         @(negedge clk);
         if (k == wid) begin
            hs = 1'b1;
            vs = 1'b1;
         end
         if (k == 2) chk({nm, ".lock_before"}, 32'(locked), 32'(last_lk));
         if (k == 3) begin
            chk({nm, ".locked"}, 32'(locked), 32'(exp_lk));
            chk({nm, ".vline"}, 32'(vline), exp_vl);
            chk_bad({nm, ".bad_lines"}, exp_bad);
         end
         if (k >= 3) begin
            exp_de = exp_lk && (k >= 292) && (k <= 1571);
            exp_px = exp_de ? (k - 292) / 10 : 0;
            if (de === 1'b1) de_cnt++;
            if (de !== exp_de || hpix !== 7'(exp_px) || locked !== exp_lk) errs++;
         end
      end
      chk({nm, ".de_span"}, de_cnt, exp_lk ? 1280 : 0);
      chk({nm, ".walk_errs"}, errs, 0);
      last_lk = exp_lk;
   endtask

   initial begin
      vec_t tbl[20];
      reset   = 1'b1;
      hs      = 1'b1;
      vs      = 1'b1;
      last_lk = 1'b0;

      // Each fall judges the previous entry's period/width.
      tbl[0]  = '{1600, 192, 1'b0, 1'b0, 0, 0};
      tbl[1]  = '{1600, 192, 1'b0, 1'b0, 0, 0};
      tbl[2]  = '{1600, 192, 1'b0, 1'b0, 0, 0};
      tbl[3]  = '{1600, 192, 1'b0, 1'b0, 0, 0};
      tbl[4]  = '{1600, 192, 1'b0, 1'b1, 0, 0};
      tbl[5]  = '{1602, 192, 1'b0, 1'b1, 1, 0};
      tbl[6]  = '{1603, 192, 1'b0, 1'b1, 2, 0};
      tbl[7]  = '{1600, 192, 1'b0, 1'b0, 3, 1};
      tbl[8]  = '{1600, 192, 1'b0, 1'b0, 3, 1};
      tbl[9]  = '{1600, 192, 1'b0, 1'b0, 3, 1};
      tbl[10] = '{1600, 192, 1'b0, 1'b0, 3, 1};
      tbl[11] = '{1600, 192, 1'b0, 1'b1, 3, 1};
      tbl[12] = '{1600, 195, 1'b0, 1'b1, 4, 1};
      tbl[13] = '{1600, 192, 1'b0, 1'b0, 5, 2};
      tbl[14] = '{1600, 192, 1'b0, 1'b0, 5, 2};
      tbl[15] = '{1600, 192, 1'b0, 1'b0, 5, 2};
      tbl[16] = '{1600, 192, 1'b0, 1'b0, 5, 2};
      tbl[17] = '{1600, 192, 1'b0, 1'b1, 5, 2};
      tbl[18] = '{1600, 192, 1'b1, 1'b1, 0, 2};
      tbl[19] = '{1600, 192, 1'b0, 1'b1, 1, 2};

      repeat (3) @(negedge clk);
      chk("rst.locked", 32'(locked), 0);
      chk("rst.de", 32'(de), 0);
      chk("rst.hpixel", 32'(hpix), 0);
      chk("rst.vline", 32'(vline), 0);
      chk_bad("rst.bad_lines", 0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst.locked", 32'(locked), 0);
      chk("post_rst.de", 32'(de), 0);

      for (int i = 0; i < 20; i++)
         do_line($sformatf("line%0d", i), tbl[i].per, tbl[i].wid, tbl[i].vs,
                 tbl[i].lk, tbl[i].vl, tbl[i].bad);

      // Asynchronous reset in the middle of the display window.
      @(negedge clk);
      hs = 1'b0;
      for (int k = 1; k < 1600; k++) begin
         @(negedge clk);
         if (k == 192) hs = 1'b1;
         if (k == 3) chk("rst_mid.vline_before", 32'(vline), 2);
         if (k == 600) begin
            chk("rst_mid.de_before", 32'(de), 1);
            chk("rst_mid.hpixel_before", 32'(hpix), 30);
            #2 reset = 1'b1;
            #1;
            chk("rst_mid.locked", 32'(locked), 0);
            chk("rst_mid.de", 32'(de), 0);
            chk("rst_mid.hpixel", 32'(hpix), 0);
            chk("rst_mid.vline", 32'(vline), 0);
            chk_bad("rst_mid.bad_lines", 0);
         end
         if (k == 603) reset = 1'b0;
      end
      last_lk = 1'b0;

      for (int i = 0; i < 5; i++)
         do_line($sformatf("reacq%0d", i), 1600, 192, 1'b0, (i == 4), 0, 0);

      // Loss of signal: hsync stays high after one pulse while locked.
      @(negedge clk);
      hs = 1'b0;
      for (int k = 1; k <= 3210; k++) begin
         @(negedge clk);
         if (k == 192) hs = 1'b1;
         if (k == 3) chk("loss.locked_start", 32'(locked), 1);
         if (k == 3203) chk("loss.locked_at_sat", 32'(locked), 1);
         if (k == 3204) begin
            chk("loss.locked_after", 32'(locked), 0);
            chk("loss.de_after", 32'(de), 0);
            chk("loss.hpixel_after", 32'(hpix), 0);
         end
         if (k == 3210) chk("loss.locked_stays", 32'(locked), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
